fir_requant_buf: RTL and testbench

FIR_REQUANT_BUF -- requirements
Module: fir_requant_buf

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_sync_fifo.sv | 48 ++++
 rtl/fir_requant_buf.sv | 128 ++++++++++++
 tb/tb_fir_requant_buf.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR requantizer/output buffer.
package fir_pkg;
  localparam int IN_W      = 17;
  localparam int OUT_W     = 8;
  localparam int SAT_LIMIT = 255;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fir_state_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO: power-of-two depth, occupancy count, write-through-on-pop when full.
module fir_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en, rd_en;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      cnt <= cnt + 1'b1;
      else if (!wr_en && rd_en) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fir_requant_buf.sv
// Requantizes 17-bit filter output to 8 bits (round, shift, saturate) after a warm-up
// discard phase, buffering results in a FIFO. Define FIR_REQUANT_STATS_EN for event counters.
module fir_requant_buf
  import fir_pkg::*;
#(
  parameter int SHIFT    = 9,
  parameter int WARMUP_N = 16,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  output logic                   warm,
`ifdef FIR_REQUANT_STATS_EN
  output logic [15:0]            sat_cnt,
  output logic [15:0]            drop_cnt,
`endif
  output fir_state_t             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);
  localparam logic [17:0] ROUND = 18'(1) << (SHIFT - 1);
  localparam fir_state_t  RESET_STATE = (WARMUP_N == 0) ? ST_RUN : ST_WARMUP;

  // Handshake: out_data is consumed on a cycle where out_valid && out_ready; the input
  // side has no ready, every in_valid cycle carries a sample that must be taken.

  logic [17:0]      q_sum, q_val;
  logic             q_sat;
  logic [OUT_W-1:0] q_out;

  assign q_sum = {1'b0, in_data} + ROUND;
  assign q_val = q_sum >> SHIFT;
  assign q_sat = (q_val > 18'(SAT_LIMIT));
  assign q_out = q_sat ? OUT_W'(SAT_LIMIT) : q_val[OUT_W-1:0];

  fir_state_t state, state_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       accept;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    accept   = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (in_valid) begin
          wcnt_nx = wcnt + 8'd1;
          if (wcnt_nx == 8'(WARMUP_N)) state_nx = ST_RUN;
        end
      end
      ST_RUN: accept = in_valid;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  logic             pipe_valid, pipe_sat;
  logic [OUT_W-1:0] pipe_data;
  logic             fifo_full, fifo_empty, pop;
  logic [OUT_W-1:0] fifo_dout;
  logic             sat_evt, drop_evt;

  assign pop      = out_valid && out_ready;
  assign sat_evt  = pipe_valid && pipe_sat;
  assign drop_evt = pipe_valid && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_sat   <= 1'b0;
      pipe_data  <= '0;
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        pipe_data <= q_out;
        pipe_sat  <= q_sat;
      end
      if (sat_evt)  sat_flag <= 1'b1;
      if (drop_evt) ovf_flag <= 1'b1;
    end
  end

  fir_sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pipe_valid),
    .din   (pipe_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  // Mask the unreset storage so an empty FIFO always presents 0x00.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_dout;
  assign warm      = (state == ST_RUN);
  assign dbg_state = state;

`ifdef FIR_REQUANT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      if (sat_evt && sat_cnt != 16'hFFFF)   sat_cnt  <= sat_cnt + 16'd1;
      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fir_requant_buf.sv
// Directed bench for fir_requant_buf: queue-based behavioural model plus literal checkpoints.
module tb_fir_requant_buf;
  import fir_pkg::*;

  localparam int SHIFT    = 9;
  localparam int WARMUP_N = 16;
  localparam int DEPTH    = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [16:0]            in_data;
  logic                   in_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_valid, sat_flag, ovf_flag, warm;
  fir_state_t             dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;
`ifdef FIR_REQUANT_STATS_EN
  logic [15:0]            sat_cnt, drop_cnt;
`endif

  fir_requant_buf #(.SHIFT(SHIFT), .WARMUP_N(WARMUP_N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .warm      (warm),
`ifdef FIR_REQUANT_STATS_EN
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: FIFO contents as a queue, one in-flight sample, sticky flags
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int   m_wcnt     = 0;
  bit   m_run      = (WARMUP_N == 0);
  bit   st_v       = 1'b0;
  bit   st_s       = 1'b0;
  logic [7:0] st_d = 8'd0;
  bit   m_sat      = 1'b0;
  bit   m_ovf      = 1'b0;
  int   m_sat_cnt  = 0;
  int   m_drop_cnt = 0;

  function automatic int quant(input int d);
    return (d + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_wcnt = 0;
      m_run  = (WARMUP_N == 0);
      st_v   = 1'b0;
      m_sat  = 1'b0;
      m_ovf  = 1'b0;
      m_sat_cnt  = 0;
      m_drop_cnt = 0;
    end else begin : upd
      int v;
      if (exp_q.size() > 0 && out_ready) got_q.push_back(exp_q.pop_front());
      if (st_v) begin
        if (st_s) begin
          m_sat = 1'b1;
          if (m_sat_cnt < 65535) m_sat_cnt++;
        end
        if (exp_q.size() < DEPTH) exp_q.push_back(st_d);
        else begin
          m_ovf = 1'b1;
          if (m_drop_cnt < 65535) m_drop_cnt++;
        end
      end
      st_v = 1'b0;
      if (in_valid) begin
        if (m_run) begin
          v    = quant(int'(in_data));
          st_v = 1'b1;
          st_s = (v > 255);
          st_d = st_s ? 8'd255 : v[7:0];
        end else begin
          m_wcnt++;
          if (m_wcnt == WARMUP_N) m_run = 1'b1;
        end
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("out_data", 32'(out_data), 32'((exp_q.size() > 0) ? exp_q[0] : 8'h00));
    check("sat_flag", 32'(sat_flag), 32'(m_sat));
    check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
    check("warm", 32'(warm), 32'(m_run));
    check("dbg_state", 32'(dbg_state), 32'(m_run ? ST_RUN : ST_WARMUP));
    check("count", 32'(dbg_count), 32'(exp_q.size()));
`ifdef FIR_REQUANT_STATS_EN
    check("sat_cnt", 32'(sat_cnt), 32'(m_sat_cnt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
`endif
  end

  // driver tasks: inputs change 1ns after the falling edge
  task automatic cyc(input logic [16:0] d, input logic v);
    in_data  = d;
    in_valid = v;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(17'd0, 1'b0);
  endtask

  function automatic int got_at(input int i);
    return (i < got_q.size()) ? int'(got_q[i]) : -1;
  endfunction

  initial begin
    reset     = 1'b1;
    in_data   = 17'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst warm", 32'(warm), 32'd0);
    check("rst flags", 32'({sat_flag, ovf_flag}), 32'd0);
    reset = 1'b0;

    // warm-up: 20 samples of 512, first 16 discarded
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(17'd512, 1'b1);
      check("warm edge", 32'(warm), 32'(i + 1 >= 16));
    end
    idle(4);
    check("warm out len", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("warm out", 32'(got_at(i)), 32'd1);
    got_q.delete();

    // rounding
    cyc(17'd255, 1'b1);
    cyc(17'd256, 1'b1);
    cyc(17'd767, 1'b1);
    cyc(17'd768, 1'b1);
    idle(4);
    check("rnd len", 32'(got_q.size()), 32'd4);
    check("rnd 255", 32'(got_at(0)), 32'd0);
    check("rnd 256", 32'(got_at(1)), 32'd1);
    check("rnd 767", 32'(got_at(2)), 32'd1);
    check("rnd 768", 32'(got_at(3)), 32'd2);
    check("rnd sat", 32'(sat_flag), 32'd0);
    got_q.delete();

    // largest non-saturating input, then saturation
    cyc(17'd130815, 1'b1);
    idle(3);
    check("max unsat", 32'(got_at(0)), 32'd255);
    check("max unsat flag", 32'(sat_flag), 32'd0);
    got_q.delete();
    cyc(17'h1FFFF, 1'b1);
    idle(3);
    check("sat out", 32'(got_at(0)), 32'd255);
    check("sat flag", 32'(sat_flag), 32'd1);
    idle(3);
    check("sat sticky", 32'(sat_flag), 32'd1);
    got_q.delete();

    // full FIFO with simultaneous pop and write
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) cyc(17'(i * 512), 1'b1);
    check("pre full count", 32'(dbg_count), 32'd8);
    out_ready = 1'b1;
    cyc(17'(10 * 512), 1'b1);
    check("full+pop count", 32'(dbg_count), 32'd8);
    check("full+pop ovf", 32'(ovf_flag), 32'd0);
    idle(1);
    check("full+pop count2", 32'(dbg_count), 32'd8);
    idle(10);
    check("full+pop len", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) check("full+pop order", 32'(got_at(i)), 32'(i + 1));
    check("full+pop ovf end", 32'(ovf_flag), 32'd0);
    got_q.delete();

    // overflow under backpressure
    out_ready = 1'b0;
    for (int i = 11; i <= 20; i++) cyc(17'(i * 512), 1'b1);
    idle(2);
    check("ovf count", 32'(dbg_count), 32'd8);
    check("ovf flag", 32'(ovf_flag), 32'd1);
    check("ovf head", 32'(out_data), 32'd11);
    idle(2);
    check("ovf head stable", 32'(out_data), 32'd11);
    out_ready = 1'b1;
    idle(10);
    check("ovf drain len", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("ovf drain", 32'(got_at(i)), 32'(i + 11));
    check("ovf drained", 32'(dbg_count), 32'd0);
    got_q.delete();

    // reset with 5 entries queued
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cyc(17'(i * 512), 1'b1);
    idle(2);
    check("pre rst count", 32'(dbg_count), 32'd5);
    in_data  = 17'd512;
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out_data", 32'(out_data), 32'd0);
    check("mid rst flags", 32'({sat_flag, ovf_flag}), 32'd0);
    check("mid rst warm", 32'(warm), 32'd0);
    @(negedge clk);
    #1;
    cyc(17'd512, 1'b1);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(17'd512, 1'b1);
      check("rewarm edge", 32'(warm), 32'(i + 1 >= 16));
    end
    cyc(17'd1024, 1'b1);
    idle(3);
    check("rewarm len", 32'(got_q.size()), 32'd1);
    check("rewarm out", 32'(got_at(0)), 32'd2);
    check("rewarm ovf", 32'(ovf_flag), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
